// File: rtl/sonar_pkg.sv
// Shared types and constants for the ultrasonic ranger and its BCD converter.
package sonar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      CONVERT,
      DONE,
      ERR
   } sonar_state_e;

   localparam int              CM_W     = 10;
   localparam logic [CM_W-1:0] CM_MAX   = 10'd999;
   localparam logic [15:0]     ERR_CODE = 16'hEEEE;

   // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
      logic [15:0] r;
      r = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to 4-digit packed BCD.
// Ten shift cycles after start; done pulses for one cycle once bcd_o is final.
module bin2bcd_seq
   import sonar_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic [CM_W-1:0] bin_i,
   output logic [15:0]     bcd_o,
   output logic            done_o
);

   logic [CM_W-1:0] bin_q, bin_d;
   logic [15:0]     bcd_q, bcd_d;
   logic [15:0]     bcd_adj;
   logic [3:0]      cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bcd_adj = bcd_adjust(bcd_q);
      if (start_i) begin
         bin_d  = bin_i;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = {bcd_adj[14:0], bin_q[CM_W-1]};
         bin_d = {bin_q[CM_W-2:0], 1'b0};
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'(CM_W - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

// File: rtl/sonar_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing in us, cm conversion, BCD output.
// Define SONAR_AVG_EN to report the running average of the last four good readings.
module sonar_ranger
   import sonar_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TRIG_US     = 10,
   parameter int PERIOD_US   = 60_000,
   parameter int TIMEOUT_US  = 30_000,
   parameter int US_PER_CM   = 58
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        echo_in,
   output logic        trig_out,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        range_err
);

   localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
   localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PER_W = $clog2(PERIOD_US);
   localparam int TO_W  = $clog2(TIMEOUT_US + 1);
   localparam int SUB_W = $clog2(US_PER_CM);

   sonar_state_e    state_q, state_d;
   logic [PS_W-1:0] ps_cnt_q;
   logic [PER_W-1:0] period_cnt_q, period_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
   logic [CM_W-1:0] cm_cnt_q, cm_cnt_d;
   logic            first_q, first_d;
   logic [15:0]     disp_q, disp_d;
   logic            range_err_q, range_err_d;
   logic            data_valid_q, data_valid_d;
   logic            echo_meta_q, echo_sync_q, echo_prev_q;
   logic            us_tick, echo_rise, conv_start, conv_done;
   logic [CM_W-1:0] conv_bin;
   logic [15:0]     conv_bcd;

   assign us_tick   = (ps_cnt_q == PS_W'(DIV - 1));
   assign echo_rise = echo_sync_q & ~echo_prev_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt_q    <= '0;
         echo_meta_q <= 1'b0;
         echo_sync_q <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         ps_cnt_q    <= us_tick ? '0 : ps_cnt_q + PS_W'(1);
         echo_meta_q <= echo_in;
         echo_sync_q <= echo_meta_q;
         echo_prev_q <= echo_sync_q;
      end
   end

`ifdef SONAR_AVG_EN
   logic [CM_W-1:0] avg_buf_q [4];
   logic [11:0]     avg_sum_q, avg_sum_next;

   assign avg_sum_next = avg_sum_q - 12'(avg_buf_q[3]) + 12'(cm_cnt_q);
   assign conv_bin     = avg_sum_next[CM_W+1:2];

   // Only completed measurements enter the window; timeouts never reach CONVERT.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) avg_buf_q[i] <= '0;
         avg_sum_q <= '0;
      end else if (conv_start) begin
         avg_buf_q[0] <= cm_cnt_q;
         for (int i = 1; i < 4; i++) avg_buf_q[i] <= avg_buf_q[i-1];
         avg_sum_q <= avg_sum_next;
      end
   end
`else
   assign conv_bin = cm_cnt_q;
`endif

   bin2bcd_seq u_bin2bcd (
      .clk_i   (clk_in),
      .rst_n_i (rst_n),
      .start_i (conv_start),
      .bin_i   (conv_bin),
      .bcd_o   (conv_bcd),
      .done_o  (conv_done)
   );

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      to_cnt_d     = to_cnt_q;
      sub_cnt_d    = sub_cnt_q;
      cm_cnt_d     = cm_cnt_q;
      first_d      = first_q;
      disp_d       = disp_q;
      range_err_d  = range_err_q;
      data_valid_d = 1'b0;
      conv_start   = 1'b0;

      if (us_tick && (period_cnt_q < PER_W'(PERIOD_US - 1)))
         period_cnt_d = period_cnt_q + PER_W'(1);
      if (us_tick && (state_q inside {TRIG, WAIT_RISE, MEASURE}))
         to_cnt_d = to_cnt_q + TO_W'(1);

      case (state_q)
         IDLE: begin
            to_cnt_d  = '0;
            sub_cnt_d = '0;
            cm_cnt_d  = '0;
            if (us_tick && (first_q || (period_cnt_q >= PER_W'(PERIOD_US - 1)))) begin
               state_d      = TRIG;
               period_cnt_d = '0;
               first_d      = 1'b0;
            end
         end
         TRIG: begin
            if (us_tick && (to_cnt_q == TO_W'(TRIG_US - 1))) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (us_tick && (to_cnt_q == TO_W'(TIMEOUT_US - 1))) begin
               state_d = ERR;
            end else if (echo_rise) begin
               state_d = MEASURE;
               // The edge cycle is already echo-high time; count its tick too.
               if (us_tick) sub_cnt_d = SUB_W'(1);
            end
         end
         MEASURE: begin
            if (!echo_sync_q) begin
               state_d    = CONVERT;
               conv_start = 1'b1;
            end else if (us_tick) begin
               if (to_cnt_q == TO_W'(TIMEOUT_US - 1)) state_d = ERR;
               if (sub_cnt_q == SUB_W'(US_PER_CM - 1)) begin
                  sub_cnt_d = '0;
                  if (cm_cnt_q != CM_MAX) cm_cnt_d = cm_cnt_q + CM_W'(1);
               end else begin
                  sub_cnt_d = sub_cnt_q + SUB_W'(1);
               end
            end
         end
         CONVERT: begin
            if (conv_done) state_d = DONE;
         end
         DONE: begin
            disp_d       = conv_bcd;
            range_err_d  = 1'b0;
            data_valid_d = 1'b1;
            state_d      = IDLE;
         end
         ERR: begin
            disp_d       = ERR_CODE;
            range_err_d  = 1'b1;
            data_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         period_cnt_q <= '0;
         to_cnt_q     <= '0;
         sub_cnt_q    <= '0;
         cm_cnt_q     <= '0;
         first_q      <= 1'b1;
         disp_q       <= '0;
         range_err_q  <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         to_cnt_q     <= to_cnt_d;
         sub_cnt_q    <= sub_cnt_d;
         cm_cnt_q     <= cm_cnt_d;
         first_q      <= first_d;
         disp_q       <= disp_d;
         range_err_q  <= range_err_d;
         data_valid_q <= data_valid_d;
      end
   end

   // Decoded straight from state so the asynchronous reset drops the trigger at once.
   assign trig_out   = (state_q == TRIG);
   assign data_out   = {16'h0000, disp_q};
   assign data_valid = data_valid_q;
   assign range_err  = range_err_q;

endmodule
